// File: rtl/acc_prd_arbiter.sv
// acc_prd_arbiter: shares one combinational predecoder among NumReq requesters with per-port
// response holding slots. Define ACC_PRD_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
package acc_pkg;
  typedef struct packed {
    logic [31:0] q_instr_data;
  } acc_prd_req_t;

  typedef struct packed {
    logic       p_accept;
    logic       p_writeback;
    logic       p_is_mem_op;
    logic [2:0] p_use_rs;
  } acc_prd_rsp_t;
endpackage

module acc_prd_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic         [NumReq-1:0]      req_valid_i,
  output logic         [NumReq-1:0]      req_ready_o,
  input  logic         [NumReq-1:0][31:0] req_instr_i,
  output logic         [NumReq-1:0]      rsp_valid_o,
  input  logic         [NumReq-1:0]      rsp_ready_i,
  output acc_prd_rsp_t [NumReq-1:0]      rsp_o,
  output acc_prd_req_t                   prd_req_o,
  input  acc_prd_rsp_t                   prd_rsp_i
);

  typedef enum logic {StIdle, StPend} slot_state_e;

  slot_state_e                 state_q [NumReq];
  acc_prd_rsp_t [NumReq-1:0]   slot_q;
  logic         [NumReq-1:0]   eligible;
  logic         [NumReq-1:0]   grant;
  logic                        gnt_valid;
  logic         [IdxW-1:0]     gnt_idx;

  // A pending slot may be refilled in the same cycle it is drained.
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] & ((state_q[i] == StIdle) | rsp_ready_i[i]);
    end
  end

`ifdef ACC_PRD_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = IdxW'((32'(ptr_q) + k) % NumReq);
      if (!gnt_valid && eligible[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_valid) begin
      ptr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!gnt_valid && eligible[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(k);
      end
    end
  end
`endif

  assign grant       = gnt_valid ? (NumReq'(1) << gnt_idx) : '0;
  assign req_ready_o = grant;

  always_comb begin
    prd_req_o = '0;
    if (gnt_valid) begin
      prd_req_o.q_instr_data = req_instr_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        state_q[i] <= StIdle;
      end
      slot_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (grant[i]) begin
          state_q[i] <= StPend;
          slot_q[i]  <= prd_rsp_i;
        end else if ((state_q[i] == StPend) && rsp_ready_i[i]) begin
          state_q[i] <= StIdle;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = (state_q[i] == StPend);
    end
  end

  assign rsp_o = slot_q;

endmodule

// File: doc/acc_prd_arbiter.md
# acc_prd_arbiter

Shares one combinational accelerator predecoder between `NumReq` requesters, such as several core offload ports or a core plus a debug/trace replayer. Each cycle it grants at most one requester and drives that requester's instruction word into the predecoder. It registers the predecoder response into a per-requester holding slot and returns it through a valid/ready handshake. It sits between the requesters' predecode stage and the `acc_prd_req_t`/`acc_prd_rsp_t` predecoder port.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, range 1..16.
- `IdxW`, default `$clog2(NumReq)` (1 when `NumReq`=1): width of the round-robin pointer; derived, never overridden.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `req_valid_i` in `[NumReq-1:0]`: requester has an instruction to predecode.
- `req_ready_o` out `[NumReq-1:0]`: grant; request handshake completes when valid and ready are both high.
- `req_instr_i` in `[NumReq-1:0][31:0]`: instruction word per requester. Must be stable while valid is high.
- `rsp_valid_o` out `[NumReq-1:0]`: held predecode result is available.
- `rsp_ready_i` in `[NumReq-1:0]`: requester consumes the result.
- `rsp_o` out `[NumReq-1:0]` `acc_pkg::acc_prd_rsp_t`: held result (`p_accept`, `p_writeback`, `p_is_mem_op`, `p_use_rs`).
- `prd_req_o` out `acc_pkg::acc_prd_req_t`: instruction presented to the shared predecoder.
- `prd_rsp_i` in `acc_pkg::acc_prd_rsp_t`: combinational predecoder answer for `prd_req_o`.

## Operation
- Each requester has a slot FSM with two states:
  - IDLE → PEND on a request handshake.
  - PEND → IDLE on a response handshake (`rsp_valid_o & rsp_ready_i`).
- Eligibility: port i is eligible when `req_valid_i[i]` is high and its slot is IDLE, or its slot is PEND and `rsp_ready_i[i]` is high in the same cycle (drain-and-refill). In the refill case the slot stays PEND and is reloaded.
- At most one grant per cycle. `req_ready_o` is one-hot or zero, and is computed combinationally from the current valids, slot states and pointer.
- On grant g:
  - `prd_req_o.q_instr_data = req_instr_i[g]`.
  - At the clock edge, `prd_rsp_i` is captured into slot g.
- With no grant, `prd_req_o.q_instr_data = 32'h0`.
- A slot register loads only on its own grant. The captured value is held unchanged while PEND.
- `rsp_o[i]` shows the slot register. It is only meaningful while `rsp_valid_o[i]` is high.
- `rsp_valid_o[i]` is high iff slot i is PEND.
- Arbitration order: see Configuration.
- The arbiter does not interpret `p_accept`. A result with `p_accept`=0 is returned like any other.

## Timing
- Reset values:
  - All slots IDLE; all slot registers zero.
  - `rsp_valid_o`=0, `rsp_o`=0.
  - Round-robin pointer = 0.
- `req_ready_o`=0 and `prd_req_o`=0 while no requester is valid.
- Latency: grant in cycle N, `rsp_valid_o` high in cycle N+1.
- Per-port throughput is one instruction per cycle when `rsp_ready_i` is held high and the port wins every cycle.
- Aggregate throughput is one grant per cycle.
- A response is held until consumed. Backpressure on `rsp_ready_i` stalls only that port. Other ports keep being served.
- Simultaneous requests are resolved by the arbitration order. Losers see `req_ready_o`=0 and must hold their request.
- Reset asserted mid-operation: all pending responses are dropped immediately, without waiting for a clock edge. Requesters must reissue.
- No combinational path from `rsp_ready_i` to `rsp_valid_o`. A path from `rsp_ready_i` to `req_ready_o` exists (refill case).

## Configuration
- Macro `ACC_PRD_ARB_ROUND_ROBIN_EN`.
- Defined:
  - Round-robin order. The search starts at the pointer and wraps modulo `NumReq`.
  - After a grant to g, the pointer becomes (g+1) mod `NumReq`. The wrap from `NumReq-1` goes to 0.
  - The pointer is unchanged on cycles without a grant.
- Undefined:
  - Fixed priority; the lowest eligible index wins.
  - The pointer register is not present.

## Test plan
- Reset, then `req_valid_i[0]`=1 with instr 32'h0000_100B and the predecoder model accepting it:
  - `req_ready_o`=2'b01 in the same cycle.
  - Next cycle `rsp_valid_o[0]`=1 with `p_accept`=1.
  - The response holds for 5 cycles with `rsp_ready_i`=0.
- Both ports valid every cycle, `rsp_ready_i`=2'b11:
  - Round-robin build: grants alternate 01,10,01,10.
  - Fixed build: port 0 is granted every cycle.
- Port 0 PEND with `rsp_ready_i[0]`=0, port 0 and port 1 both valid:
  - Port 1 is granted every cycle.
  - Port 0 `req_ready_o` stays 0 until `rsp_ready_i[0]`=1, then it is refilled in that same cycle.
- Instr 32'hFFFF_FFFF with the predecoder returning all zeros:
  - `rsp_valid_o` high one cycle later with `rsp_o`=0 (`p_accept`=0).
  - The slot returns to IDLE on consumption.
- `NumReq`=3, round-robin build, pointer at 2, ports 0 and 2 valid:
  - Port 2 is granted, the pointer wraps to 0, and port 0 is granted next.
- `rst_ni` low while both slots are PEND:
  - `rsp_valid_o`=0 before the next clock edge.
  - After reset, the first grant goes to port 0.
